// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on input and output,
// registered result and status flags, and a multi-cycle shifter.
// Op codes follow the MIPS funct encoding of the earlier combinational ALU.
// Optional build macro: ALU_SEQ_FAST_SHIFT_EN selects a single-cycle barrel
// shifter instead of the one-bit-per-cycle iterative shifter.
module alu_seq #(
    parameter int NB_DATA  = 8,
    parameter int NB_CODE  = 6,
    parameter int NB_SHAMT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NB_DATA-1:0] dato1,
    input  logic [NB_DATA-1:0] dato2,
    input  logic [NB_CODE-1:0] op_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NB_DATA-1:0] salida,
    output logic               zero,
    output logic               carry,
    output logic               overflow,
    output logic               op_err
);

    localparam int MSB = NB_DATA - 1;

    localparam logic [NB_CODE-1:0] OP_ADD = NB_CODE'(6'b100000);
    localparam logic [NB_CODE-1:0] OP_SUB = NB_CODE'(6'b100010);
    localparam logic [NB_CODE-1:0] OP_AND = NB_CODE'(6'b100100);
    localparam logic [NB_CODE-1:0] OP_OR  = NB_CODE'(6'b100101);
    localparam logic [NB_CODE-1:0] OP_XOR = NB_CODE'(6'b100110);
    localparam logic [NB_CODE-1:0] OP_NOR = NB_CODE'(6'b100111);
    localparam logic [NB_CODE-1:0] OP_SRA = NB_CODE'(6'b000011);
    localparam logic [NB_CODE-1:0] OP_SRL = NB_CODE'(6'b000010);

    // Shift amounts at or above the data width saturate to this value
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);
`ifndef ALU_SEQ_FAST_SHIFT_EN
    localparam logic [NB_SHAMT-1:0] SHAMT_MAX = NB_SHAMT'(NB_DATA);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   a_q, a_d;
    logic [NB_DATA-1:0]   b_q, b_d;
    logic [NB_CODE-1:0]   op_q, op_d;
    logic [NB_SHAMT-1:0]  cnt_q, cnt_d;
    logic [NB_DATA-1:0]   salida_q, salida_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 overflow_q, overflow_d;
    logic                 op_err_q, op_err_d;

    logic [NB_SHAMT-1:0]  load_cnt;
    logic [NB_DATA-1:0]   shift_one;
    logic [NB_DATA:0]     sum_ext;
    logic [NB_DATA:0]     diff_ext;
    logic [NB_DATA-1:0]   res_val;
    logic                 res_carry;
    logic                 res_ovf;
    logic                 res_err;

    // Number of single-bit shift steps to run for the operation being accepted
    always_comb begin
        load_cnt = '0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
        if (op_code == OP_SRA || op_code == OP_SRL) begin
            if (dato2 >= SHIFT_LIMIT) begin
                load_cnt = SHAMT_MAX;
            end else begin
                load_cnt = dato2[NB_SHAMT-1:0];
            end
        end
`endif
    end

    // One-bit shift step of the accumulator: SRA refills with the sign bit
    always_comb begin
        shift_one = {1'b0, a_q[MSB:1]};
        if (op_q == OP_SRA) begin
            shift_one = {a_q[MSB], a_q[MSB:1]};
        end
    end

    // Final result and flags from the captured operands (and shifted accumulator)
    always_comb begin
        sum_ext   = {1'b0, a_q} + {1'b0, b_q};
        diff_ext  = {1'b0, a_q} - {1'b0, b_q};
        res_val   = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_err   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_val   = sum_ext[MSB:0];
                res_carry = sum_ext[NB_DATA];
                res_ovf   = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                res_val   = diff_ext[MSB:0];
                res_carry = diff_ext[NB_DATA];
                res_ovf   = (a_q[MSB] != b_q[MSB]) && (diff_ext[MSB] != a_q[MSB]);
            end
            OP_AND: res_val = a_q & b_q;
            OP_OR:  res_val = a_q | b_q;
            OP_XOR: res_val = a_q ^ b_q;
            OP_NOR: res_val = ~(a_q | b_q);
`ifdef ALU_SEQ_FAST_SHIFT_EN
            OP_SRL: begin
                if (b_q >= SHIFT_LIMIT) begin
                    res_val = '0;
                end else begin
                    res_val = a_q >> b_q;
                end
            end
            OP_SRA: begin
                if (b_q >= SHIFT_LIMIT) begin
                    res_val = {NB_DATA{a_q[MSB]}};
                end else begin
                    res_val = $signed(a_q) >>> b_q;
                end
            end
`else
            OP_SRL: res_val = a_q;
            OP_SRA: res_val = a_q;
`endif
            default: begin
                res_val = '0;
                res_err = 1'b1;
            end
        endcase
    end

    // Next-state and datapath update for the IDLE / EXEC / DONE sequence
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        salida_d   = salida_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        op_err_d   = op_err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = dato1;
                    b_d     = dato2;
                    op_d    = op_code;
                    cnt_d   = load_cnt;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    a_d   = shift_one;
                    cnt_d = cnt_q - NB_SHAMT'(1);
                end else begin
                    salida_d   = res_val;
                    zero_d     = !res_err && (res_val == '0);
                    carry_d    = res_carry;
                    overflow_d = res_ovf;
                    op_err_d   = res_err;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            salida_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            salida_q   <= salida_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            op_err_q   <= op_err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign salida    = salida_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq. The driver pushes the expected
// result of every accepted operation; a monitor pops and compares whenever
// the DUT presents a result.
module tb_alu_seq;

    localparam int NB_DATA  = 8;
    localparam int NB_CODE  = 6;
    localparam int NB_SHAMT = 4;

    localparam logic [5:0] C_ADD = 6'b100000;
    localparam logic [5:0] C_SUB = 6'b100010;
    localparam logic [5:0] C_AND = 6'b100100;
    localparam logic [5:0] C_OR  = 6'b100101;
    localparam logic [5:0] C_XOR = 6'b100110;
    localparam logic [5:0] C_NOR = 6'b100111;
    localparam logic [5:0] C_SRA = 6'b000011;
    localparam logic [5:0] C_SRL = 6'b000010;

    typedef struct {
        int res;
        int z;
        int c;
        int v;
        int e;
        int accept;
        int k;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [NB_DATA-1:0] dato1 = '0;
    logic [NB_DATA-1:0] dato2 = '0;
    logic [NB_CODE-1:0] op_code = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [NB_DATA-1:0] salida;
    logic               zero;
    logic               carry;
    logic               overflow;
    logic               op_err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen = 0;
    bit   rnd_ready = 0;
    exp_t sb[$];

    alu_seq #(
        .NB_DATA (NB_DATA),
        .NB_CODE (NB_CODE),
        .NB_SHAMT(NB_SHAMT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dato1    (dato1),
        .dato2    (dato2),
        .op_code  (op_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .salida   (salida),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow),
        .op_err   (op_err)
    );

    // 10 ns clock and an edge counter read only at falling edges
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer back-pressure, changed just after the rising edge
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Hard time limit so the bench always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: results straight from the arithmetic definition of each op
    function automatic exp_t model(input logic [5:0] op, input int a, input int b);
        exp_t e;
        int   sa, sb, r;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        e.c = 0; e.v = 0; e.e = 0; e.k = 0; e.accept = 0;
        r = 0;
        case (op)
            C_ADD: begin r = a + b; e.c = (r > 255); e.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
            C_SUB: begin r = a - b; e.c = (a < b);   e.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
            C_AND: r = a & b;
            C_OR:  r = a | b;
            C_XOR: r = a ^ b;
            C_NOR: r = ~(a | b);
            C_SRL: begin r = (b >= 8) ? 0 : (a >> b); e.k = (b >= 8) ? 8 : b; end
            C_SRA: begin r = (b >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> b); e.k = (b >= 8) ? 8 : b; end
            default: begin r = 0; e.e = 1; end
        endcase
`ifdef ALU_SEQ_FAST_SHIFT_EN
        e.k = 0;
`endif
        e.res = r & 255;
        e.z   = (e.e == 0) && (e.res == 0);
        return e;
    endfunction

    // Present an operation at a falling edge and hold it until accepted
    task automatic applyStimulus(input logic [5:0] op, input int a, input int b, input bit expect_out);
        exp_t e;
        bit   ok;
        ok = 0;
        op_code  = op;
        dato1    = 8'(a);
        dato2    = 8'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                e = model(op, a, b);
                e.accept = cyc + 1;
                if (expect_out) sb.push_back(e);
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        dato1    = 8'($urandom);
        dato2    = 8'($urandom);
        op_code  = 6'($urandom);
        if (!ok) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic setReady(input bit v);
        @(posedge clk);
        #1 out_ready = v;
        @(negedge clk);
    endtask

    task automatic waitDrain();
        bit done;
        done = 0;
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && in_ready) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (!done) checkOutput("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: compares every cycle a result is presented, pops on handshake
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            seen = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                e = sb[0];
                if (!seen) begin
                    seen = 1;
                    checkOutput("latency", cyc + 1 - e.accept, 2 + e.k);
                end
                checkOutput("salida", int'(salida), e.res);
                checkOutput("zero", int'(zero), e.z);
                checkOutput("carry", int'(carry), e.c);
                checkOutput("overflow", int'(overflow), e.v);
                checkOutput("op_err", int'(op_err), e.e);
                checkOutput("in_ready_busy", int'(in_ready), 0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        int         a, b;
        bit         got;
        ops = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_NOR, C_SRA, C_SRL};

        // Reset held for two cycles
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_salida", int'(salida), 0);
        checkOutput("reset_flags", int'({zero, carry, overflow, op_err}), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        setReady(1);

        // Directed cases
        applyStimulus(C_ADD, 8'h7F, 8'h01, 1);
        applyStimulus(C_SUB, 8'h05, 8'h05, 1);
        applyStimulus(C_SUB, 8'h03, 8'h05, 1);
        applyStimulus(C_SRA, 8'h90, 3, 1);
        applyStimulus(C_SRL, 8'h90, 3, 1);
        applyStimulus(C_SRA, 8'h90, 9, 1);
        applyStimulus(C_SRL, 8'h90, 9, 1);
        applyStimulus(C_AND, 8'hA5, 8'h3C, 1);
        applyStimulus(C_OR,  8'hA5, 8'h3C, 1);
        applyStimulus(C_XOR, 8'hA5, 8'h3C, 1);
        applyStimulus(C_NOR, 8'hA5, 8'h3C, 1);
        applyStimulus(6'b111111, 8'h12, 8'h34, 1);
        applyStimulus(C_ADD, 8'hFF, 8'h01, 1);
        waitDrain();

        // Randomized operations with random consumer back-pressure
        rnd_ready = 1;
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            a = int'($urandom_range(0, 255));
            b = (op == C_SRA || op == C_SRL) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
            applyStimulus(op, a, b, 1);
        end
        rnd_ready = 0;
        setReady(1);
        waitDrain();

        // Back-pressure: result held five cycles while new requests are offered
        setReady(0);
        applyStimulus(C_SUB, 8'h10, 8'h20, 1);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) checkOutput("bp_out_valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op_code  = C_AND;
            dato1    = 8'($urandom);
            dato2    = 8'($urandom);
            checkOutput("bp_in_ready", int'(in_ready), 0);
            checkOutput("bp_out_valid", int'(out_valid), 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        setReady(1);
        @(negedge clk);
        checkOutput("bp_return_in_ready", int'(in_ready), 1);
        checkOutput("bp_return_out_valid", int'(out_valid), 0);
        waitDrain();

        // Reset in the middle of an SRL by 7: no result may appear
        applyStimulus(C_SRL, 8'hF0, 7, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_salida", int'(salida), 0);
        checkOutput("abort_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 15; i++) @(negedge clk);
        checkOutput("abort_queue", sb.size(), 0);

        // One more operation after the abort to confirm normal service
        applyStimulus(C_XOR, 8'h0F, 8'hFF, 1);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
